// File: rtl/piso_stream_if.sv
// rtl/piso_stream_if.sv - load/serial handshake bundle for piso_stream
interface piso_stream_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic [N-1:0]  data_in;
    logic          load_valid;
    logic          load_ready;
    logic          msb_first;
    logic          shift_en;
    logic          q;
    logic          q_valid;
    logic          done;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    modport master (
        output data_in, load_valid, msb_first, shift_en,
        input  load_ready, q, q_valid, done, busy, bit_cnt
    );

    modport slave (
        input  data_in, load_valid, msb_first, shift_en,
        output load_ready, q, q_valid, done, busy, bit_cnt
    );
endinterface

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in/serial-out shifter with load handshake and per-frame direction
module piso_stream #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst,
    piso_stream_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_next;
    logic [N-1:0]  shreg, shreg_next;
    logic          dir, dir_next;
    logic          q_r, q_next;
    logic          q_valid_r, q_valid_next;
    logic          done_r, done_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          shift, last, ready, accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            dir       <= 1'b0;
            q_r       <= 1'b0;
            q_valid_r <= 1'b0;
            done_r    <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            dir       <= dir_next;
            q_r       <= q_next;
            q_valid_r <= q_valid_next;
            done_r    <= done_next;
            cnt       <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        dir_next     = dir;
        q_next       = q_r;
        q_valid_next = 1'b0;
        done_next    = 1'b0;
        cnt_next     = cnt;

        shift  = (state == SHIFT) && bus.shift_en;
        last   = shift && (cnt == CW'(N - 1));
        ready  = (state == IDLE) || last;
        accept = bus.load_valid && ready;

        if (shift) begin
            q_next       = dir ? shreg[N-1] : shreg[0];
            shreg_next   = dir ? (shreg << 1) : (shreg >> 1);
            q_valid_next = 1'b1;
            cnt_next     = cnt + CW'(1);
            if (last) begin
                done_next  = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
        end

        // A load on the last-bit edge overrides the return to IDLE for a gapless handoff.
        if (accept) begin
            shreg_next = bus.data_in;
            dir_next   = bus.msb_first;
            cnt_next   = '0;
            state_next = SHIFT;
        end
    end

    assign bus.load_ready = ready;
    assign bus.q          = q_r;
    assign bus.q_valid    = q_valid_r;
    assign bus.done       = done_r;
    assign bus.busy       = (state == SHIFT);
    assign bus.bit_cnt    = cnt;
endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - randomized and directed self-checking bench for piso_stream
module tb_piso_stream;
    localparam int N  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bit   fq[$];
    bit   exp_q, exp_qv, exp_done;

    piso_stream_if #(.N(N), .CW(CW)) bus ();
    piso_stream #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic lv, input logic [N-1:0] d,
                        input logic m, input logic se);
        bit lr;
        @(negedge clk);
        rst            = r;
        bus.load_valid = lv;
        bus.data_in    = d;
        bus.msb_first  = m;
        bus.shift_en   = se;
        #1;
        lr = (fq.size() == 0) || (fq.size() == 1 && se);
        if (!r) chk("load_ready", 32'(bus.load_ready), 32'(lr));
        @(posedge clk);
        if (r) begin
            fq.delete();
            exp_q = 0; exp_qv = 0; exp_done = 0;
        end else begin
            exp_qv = 0; exp_done = 0;
            if (se && fq.size() > 0) begin
                exp_q    = fq.pop_front();
                exp_qv   = 1;
                exp_done = (fq.size() == 0);
            end
            if (lv && lr) begin
                for (int i = 0; i < N; i++) fq.push_back(m ? d[N-1-i] : d[i]);
            end
        end
        #1;
        chk("q", 32'(bus.q), 32'(exp_q));
        chk("q_valid", 32'(bus.q_valid), 32'(exp_qv));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("busy", 32'(bus.busy), 32'(fq.size() != 0));
        chk("bit_cnt", 32'(bus.bit_cnt), (fq.size() != 0) ? 32'(N - fq.size()) : 32'd0);
    endtask

    initial begin
        bus.load_valid = 0;
        bus.data_in    = '0;
        bus.msb_first  = 0;
        bus.shift_en   = 0;
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'hAA, 1, 1);

        // MSB-first 0xC1
        step(0, 1, 8'hC1, 1, 0);
        for (int i = 0; i < N; i++) step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);

        // LSB-first 0xC1 with msb_first toggling mid-frame
        step(0, 1, 8'hC1, 0, 1);
        for (int i = 0; i < N; i++) step(0, 0, 8'h00, i[0], 1);

        // stall after 3rd bit
        step(0, 1, 8'hC1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 1);

        // back-to-back 0xC1 then 0x81
        step(0, 1, 8'hC1, 1, 0);
        for (int i = 0; i < N - 1; i++) step(0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h81, 1, 1);
        for (int i = 0; i < N; i++) step(0, 0, 8'h00, 0, 1);

        // reset mid-frame, then fresh load
        step(0, 1, 8'hFF, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 0, 1);
        step(0, 1, 8'h0F, 1, 1);
        for (int i = 0; i < N; i++) step(0, 0, 8'h00, 0, 1);

        // load attempt while busy is ignored until the last-bit edge
        step(0, 1, 8'hC1, 1, 1);
        for (int i = 0; i < N; i++) step(0, 1, 8'h55, 0, 1);
        for (int i = 0; i < N; i++) step(0, 0, 8'h00, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), N'($urandom),
                 $urandom_range(1), ($urandom_range(3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
